// File: rtl/gate_bist_checker.sv
// Self-test engine for a 2-input combinational gate: walks {a,b} through 11,10,00,01,
// samples y after a settle interval and reports mismatch count, first failing vector and pass/fail.
module gate_bist_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT_TT     = 4'b1110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("gate_bist_checker: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] pat_idx_q, pat_idx_d;
    logic [1:0] ab_q, ab_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       rv_q, rv_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [1:0] ff_q, ff_d;
    logic       mismatch;

    // Fixed vector order: pattern index -> {a,b}.
    function automatic logic [1:0] vec_of(input logic [1:0] idx);
        logic [1:0] v;
        case (idx)
            2'd0:    v = 2'b11;
            2'd1:    v = 2'b10;
            2'd2:    v = 2'b00;
            default: v = 2'b01;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pat_idx_q <= '0;
            ab_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ff_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pat_idx_q <= pat_idx_d;
            ab_q      <= ab_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rv_q      <= rv_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ff_q      <= ff_d;
        end
    end

    // Outputs are registered, so each is computed here for the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_idx_d = pat_idx_q;
        ab_d      = ab_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rv_d      = rv_q;
        pass_d    = pass_q;
        err_d     = err_q;
        ff_d      = ff_q;
        mismatch  = 1'b0;

        case (state_q)
            IDLE: begin
                ab_d   = 2'b00;
                busy_d = 1'b0;
                if (start) begin
                    err_d     = '0;
                    ff_d      = '0;
                    pass_d    = 1'b0;
                    rv_d      = 1'b0;
                    pat_idx_d = 2'd0;
                    ab_d      = vec_of(2'd0);
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SETTLE;
                end
            end

            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                mismatch = (y_in != EXPECT_TT[ab_q]);
                if (mismatch) begin
                    err_d = err_q + 3'd1;
                    if (err_q == 3'd0) begin
                        ff_d = ab_q;
                    end
                end
                if (pat_idx_q != 2'd3) begin
                    pat_idx_d = pat_idx_q + 2'd1;
                    ab_d      = vec_of(pat_idx_q + 2'd1);
                    cnt_d     = '0;
                    state_d   = SETTLE;
                end else begin
                    ab_d    = 2'b00;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rv_d    = 1'b1;
                    pass_d  = (err_d == 3'd0);
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a_out        = ab_q[1];
    assign b_out        = ab_q[0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign first_fail   = ff_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: two instances (default and SETTLE_CYCLES=1 / AND table) driven
// by modelled gates; expected results come from a truth-table reference model.
module tb_gate_bist_checker;

    // Instance 0: SETTLE=2, OR table. Instance 1: SETTLE=1, AND table.
    localparam logic [7:0] S_TAB  = {4'd1, 4'd2};
    localparam logic [7:0] TT_TAB = {4'b1000, 4'b1110};

    logic clk;
    logic rst_n;

    logic [1:0]      start_v;
    logic [1:0]      y_v;
    logic [1:0]      a_v;
    logic [1:0]      b_v;
    logic [1:0]      busy_v;
    logic [1:0]      done_v;
    logic [1:0]      rv_v;
    logic [1:0]      pass_v;
    logic [1:0][2:0] err_v;
    logic [1:0][1:0] ff_v;
    logic [1:0][3:0] gate_tt;

    logic [1:0] order [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

    int vectors    = 0;
    int miscompares = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            assign y_v[gi] = gate_tt[gi][{a_v[gi], b_v[gi]}];

            gate_bist_checker #(
                .SETTLE_CYCLES(int'(S_TAB[gi*4 +: 4])),
                .EXPECT_TT    (TT_TAB[gi*4 +: 4])
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .start       (start_v[gi]),
                .y_in        (y_v[gi]),
                .a_out       (a_v[gi]),
                .b_out       (b_v[gi]),
                .busy        (busy_v[gi]),
                .done        (done_v[gi]),
                .result_valid(rv_v[gi]),
                .pass        (pass_v[gi]),
                .err_count   (err_v[gi]),
                .first_fail  (ff_v[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count {a,b} points where the connected gate disagrees with the expected table.
    function automatic void ref_model(input logic [3:0] ett, input logic [3:0] gtt,
                                      output int errs, output logic [1:0] ff);
        errs = 0;
        ff   = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (gtt[order[i]] != ett[order[i]]) begin
                if (errs == 0) ff = order[i];
                errs++;
            end
        end
    endfunction

    task automatic check_all_zero(input int w, input string tag);
        chk({tag, " a"},    8'(a_v[w]),    8'd0);
        chk({tag, " b"},    8'(b_v[w]),    8'd0);
        chk({tag, " busy"}, 8'(busy_v[w]), 8'd0);
        chk({tag, " done"}, 8'(done_v[w]), 8'd0);
        chk({tag, " rv"},   8'(rv_v[w]),   8'd0);
        chk({tag, " pass"}, 8'(pass_v[w]), 8'd0);
        chk({tag, " err"},  8'(err_v[w]),  8'd0);
        chk({tag, " ff"},   8'(ff_v[w]),   8'd0);
    endtask

    // Starts at a negedge with the DUT idle; checks every cycle from accept to one past done.
    // pulse_a/pulse_b: cycles in which start is raised while the pass runs (-1 = none).
    task automatic run_pass(input int w, input logic [3:0] gtt, input int pulse_a,
                            input int pulse_b, input bit hold);
        int         s;
        int         n;
        int         errs;
        logic [1:0] ff;
        logic [1:0] vec;
        string      t;
        s = int'(S_TAB[w*4 +: 4]);
        n = 4 * (s + 1);
        ref_model(TT_TAB[w*4 +: 4], gtt, errs, ff);
        gate_tt[w] = gtt;
        start_v[w] = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            start_v[w] = hold || (k == pulse_a) || (k == pulse_b);
            t = $sformatf("d%0d tt%b c%0d", w, gtt, k);
            if (k < n) begin
                vec = order[k / (s + 1)];
                chk({t, " busy"}, 8'(busy_v[w]), 8'd1);
                chk({t, " done"}, 8'(done_v[w]), 8'd0);
                chk({t, " rv"},   8'(rv_v[w]),   8'd0);
                chk({t, " ab"},   8'({a_v[w], b_v[w]}), 8'(vec));
            end else begin
                chk({t, " done"}, 8'(done_v[w]), 8'd1);
                chk({t, " busy"}, 8'(busy_v[w]), 8'd0);
                chk({t, " ab"},   8'({a_v[w], b_v[w]}), 8'd0);
                chk({t, " rv"},   8'(rv_v[w]),   8'd1);
                chk({t, " pass"}, 8'(pass_v[w]), 8'(errs == 0));
                chk({t, " err"},  8'(err_v[w]),  8'(errs));
                chk({t, " ff"},   8'(ff_v[w]),   8'(ff));
            end
        end
        @(negedge clk);
        start_v[w] = hold;
        t = $sformatf("d%0d tt%b post", w, gtt);
        chk({t, " done"}, 8'(done_v[w]), 8'd0);
        chk({t, " busy"}, 8'(busy_v[w]), 8'd0);
        chk({t, " rv"},   8'(rv_v[w]),   8'd1);
        chk({t, " err"},  8'(err_v[w]),  8'(errs));
        chk({t, " ff"},   8'(ff_v[w]),   8'(ff));
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = 2'b00;
        gate_tt = {4'b1000, 4'b1110};
        repeat (3) @(negedge clk);
        check_all_zero(0, "rst d0");
        check_all_zero(1, "rst d1");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed passes on the default instance: OR, stuck-0, stuck-1, AND.
        run_pass(0, 4'b1110, -1, -1, 1'b0);
        run_pass(0, 4'b0000, -1, -1, 1'b0);
        run_pass(0, 4'b1111, -1, -1, 1'b0);
        run_pass(0, 4'b1000, -1, -1, 1'b0);

        // Starts mid-pass and in DONE are ignored; a fresh start repeats the result.
        run_pass(0, 4'b1110, 3, 8, 1'b0);
        run_pass(0, 4'b1110, 12, -1, 1'b0);

        // Start held high relaunches right after DONE.
        run_pass(0, 4'b1110, -1, -1, 1'b1);
        run_pass(0, 4'b0110, -1, -1, 1'b0);

        // SETTLE_CYCLES=1 with an AND table.
        run_pass(1, 4'b1000, -1, -1, 1'b0);
        run_pass(1, 4'b1110, -1, -1, 1'b0);

        // Reset mid-pass: outputs clear without a clock edge, no done pulse.
        gate_tt[0] = 4'b1110;
        start_v[0] = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        start_v[0] = 1'b0;
        chk("abort pre busy", 8'(busy_v[0]), 8'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero(0, "abort async");
        repeat (3) begin
            @(negedge clk);
            chk("abort hold done", 8'(done_v[0]), 8'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort idle busy", 8'(busy_v[0]), 8'd0);
            chk("abort idle done", 8'(done_v[0]), 8'd0);
        end
        run_pass(0, 4'b1110, -1, -1, 1'b0);

        // Random gate truth tables on random instances.
        for (int r = 0; r < 12; r++) begin
            run_pass(int'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                     int'($urandom_range(14, 0)) - 1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
